// File: rtl/ca3_pattern_sequencer.sv
// ca3_pattern_sequencer
//   Theta-locked initiator for ca3_phase_memory. Runs a fixed program: present
//   pat_a REPS times, then pat_b REPS times, each on a theta peak with a
//   learning handshake. It then presents cue_a and cue_b on theta troughs and
//   latches the pattern CA3 recalls after each cue.
// Ports
//   clk, rst        system clock, async active-high reset
//   clk_en          update strobe; every register advances only when high
//   start           launches the program from IDLE or DONE
//   theta_x         signed theta oscillator x output (WIDTH bits, FRAC fraction)
//   learning        CA3 learning level handshake
//   recalling       CA3 recalling level handshake
//   phase_pattern   pattern recalled by CA3
//   pat_a, pat_b    patterns to learn
//   cue_a, cue_b    partial recall cues
//   pattern_out     drives CA3 pattern_in
//   busy / done     program running / finished (done held until start or rst)
//   error           a wait state timed out (valid with done)
//   learn_count     completed learning handshakes, saturating at 31
//   recall_a/_b     patterns latched after cue A / cue B
//
// state   | meaning
// IDLE    | waiting for start after reset
// PEAK    | presenting pat_a/pat_b, waiting for a theta peak
// LWAIT   | pattern held, waiting for learning to rise
// LHOLD   | waiting for learning to fall
// TROUGH  | pattern off, waiting for a theta trough
// GAPW    | idle for GAP updates, then choose the next presentation
// RTROUGH | waiting for a theta trough before presenting a cue
// RWAIT   | cue held, waiting for recalling to rise
// RHOLD   | waiting for recalling to fall, then latch the recalled pattern
// DONE    | program finished or timed out
module ca3_pattern_sequencer #(
    parameter int WIDTH     = 18,
    parameter int FRAC      = 14,
    parameter int N_UNITS   = 6,
    parameter int REPS      = 5,
    parameter int PEAK_TH   = 12288,
    parameter int TROUGH_TH = -12288,
    parameter int GAP       = 50,
    parameter int TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   theta_x,
    input  logic                      learning,
    input  logic                      recalling,
    input  logic [N_UNITS-1:0]        phase_pattern,
    input  logic [N_UNITS-1:0]        pat_a,
    input  logic [N_UNITS-1:0]        pat_b,
    input  logic [N_UNITS-1:0]        cue_a,
    input  logic [N_UNITS-1:0]        cue_b,
    output logic [N_UNITS-1:0]        pattern_out,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [4:0]                learn_count,
    output logic [N_UNITS-1:0]        recall_a,
    output logic [N_UNITS-1:0]        recall_b
);

    // FRAC only documents the scaling of the thresholds; no arithmetic needs it.
    localparam int frac_bits_unused = FRAC;

    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [WIDTH-1:0] PEAK_V   = WIDTH'(PEAK_TH);
    localparam logic signed [WIDTH-1:0] TROUGH_V = WIDTH'(TROUGH_TH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    REPS_V   = 4'(REPS);

    typedef enum logic [3:0] {
        IDLE, PEAK, LWAIT, LHOLD, TROUGH, GAPW, RTROUGH, RWAIT, RHOLD, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [3:0]          rep_q, rep_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [N_UNITS-1:0]  pattern_out_q, pattern_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [4:0]          learn_count_q, learn_count_d;
    logic [N_UNITS-1:0]  recall_a_q, recall_a_d;
    logic [N_UNITS-1:0]  recall_b_q, recall_b_d;
    logic                timed_state;

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        rep_d         = rep_q;
        gap_d         = gap_q;
        tmo_d         = tmo_q;
        pattern_out_d = pattern_out_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        learn_count_d = learn_count_q;
        recall_a_d    = recall_a_q;
        recall_b_d    = recall_b_q;
        timed_state   = state_q inside {PEAK, LWAIT, LHOLD, TROUGH, RTROUGH, RWAIT, RHOLD};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    learn_count_d = '0;
                    recall_a_d    = '0;
                    recall_b_d    = '0;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    step_d        = 2'd0;
                    rep_d         = 4'd0;
                    busy_d        = 1'b1;
                    pattern_out_d = pat_a;
                    state_d       = PEAK;
                end
            end
            PEAK: begin
                pattern_out_d = (step_q == 2'd0) ? pat_a : pat_b;
                if (theta_x >= PEAK_V) state_d = LWAIT;
            end
            LWAIT: if (learning) state_d = LHOLD;
            LHOLD: begin
                if (!learning) begin
                    pattern_out_d = '0;
                    if (learn_count_q != 5'd31) learn_count_d = learn_count_q + 5'd1;
                    rep_d   = rep_q + 4'd1;
                    state_d = TROUGH;
                end
            end
            TROUGH: if (theta_x <= TROUGH_V) state_d = GAPW;
            GAPW: begin
                if (gap_q == GAP_LAST) begin
                    if (step_q == 2'd2) begin
                        step_d  = 2'd3;
                        state_d = RTROUGH;
                    end else if (step_q == 2'd3) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (rep_q < REPS_V) begin
                        pattern_out_d = (step_q == 2'd0) ? pat_a : pat_b;
                        state_d       = PEAK;
                    end else begin
                        // Learning of the current pattern is complete.
                        rep_d  = 4'd0;
                        step_d = step_q + 2'd1;
                        if (step_q == 2'd0) begin
                            pattern_out_d = pat_b;
                            state_d       = PEAK;
                        end else begin
                            state_d = RTROUGH;
                        end
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            RTROUGH: begin
                if (theta_x <= TROUGH_V) begin
                    pattern_out_d = (step_q == 2'd2) ? cue_a : cue_b;
                    state_d       = RWAIT;
                end
            end
            RWAIT: if (recalling) state_d = RHOLD;
            RHOLD: begin
                if (!recalling) begin
                    if (step_q == 2'd2) recall_a_d = phase_pattern;
                    else                recall_b_d = phase_pattern;
                    pattern_out_d = '0;
                    state_d       = GAPW;
                end
            end
            default: state_d = IDLE;
        endcase

        // Wait-state watchdog: only runs while the state is not being left.
        if (timed_state && state_d == state_q) begin
            if (tmo_q == TMO_LAST) begin
                pattern_out_d = '0;
                error_d       = 1'b1;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = DONE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            tmo_d = '0;
            gap_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            step_q        <= 2'd0;
            rep_q         <= 4'd0;
            gap_q         <= '0;
            tmo_q         <= '0;
            pattern_out_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            learn_count_q <= 5'd0;
            recall_a_q    <= '0;
            recall_b_q    <= '0;
        end else if (clk_en) begin
            state_q       <= state_d;
            step_q        <= step_d;
            rep_q         <= rep_d;
            gap_q         <= gap_d;
            tmo_q         <= tmo_d;
            pattern_out_q <= pattern_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            learn_count_q <= learn_count_d;
            recall_a_q    <= recall_a_d;
            recall_b_q    <= recall_b_d;
        end
    end

    assign pattern_out = pattern_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign learn_count = learn_count_q;
    assign recall_a    = recall_a_q;
    assign recall_b    = recall_b_q;

endmodule

// File: tb/tb_ca3_pattern_sequencer.sv
module tb_ca3_pattern_sequencer;

    localparam int GAP     = 50;
    localparam int TIMEOUT = 4096;
    localparam logic signed [17:0] PEAK_TH   = 18'sd12288;
    localparam logic signed [17:0] TROUGH_TH = -18'sd12288;
    localparam logic [5:0] PA = 6'b101010, PB = 6'b010101;
    localparam logic [5:0] CA = 6'b100000, CB = 6'b000001;
    localparam logic [5:0] RA = 6'b101011, RB = 6'b110101;

    logic clk = 1'b0;
    logic rst, clk_en, start, learning, recalling;
    logic signed [17:0] theta_x;
    logic [5:0] phase_pattern, pat_a, pat_b, cue_a, cue_b;
    logic [5:0] pattern_out, recall_a, recall_b;
    logic busy, done, error;
    logic [4:0] learn_count;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    ca3_pattern_sequencer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .theta_x(theta_x),
        .learning(learning), .recalling(recalling), .phase_pattern(phase_pattern),
        .pat_a(pat_a), .pat_b(pat_b), .cue_a(cue_a), .cue_b(cue_b),
        .pattern_out(pattern_out), .busy(busy), .done(done), .error(error),
        .learn_count(learn_count), .recall_a(recall_a), .recall_b(recall_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [5:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, obs, {26'd0, e});
        end
    endtask

    // mode 0: next is PEAK, 1: next is RTROUGH, 2: next is DONE
    task automatic gap_phase(input int mode, input bit pause);
        theta_x = (mode == 1) ? TROUGH_TH : 18'sd0;
        if (pause) begin
            repeat (2) tick();
            clk_en = 1'b0;
            theta_x = PEAK_TH;
            repeat (200) tick();
            chk("pause_pattern", pattern_out, 0);
            chk("pause_busy", busy, 1);
            chk("pause_count", learn_count, 3);
            clk_en = 1'b1;
            theta_x = 18'sd0;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (GAP - 4) tick();
        end else begin
            repeat (GAP - 1) tick();
        end
        chk("gap_last_pattern", pattern_out, 0);
        chk("gap_last_busy", busy, 1);
        tick();
        if (mode == 2) begin
            chk("done_flag", done, 1);
            chk("done_busy", busy, 0);
            chk("done_error", error, 0);
        end else if (mode == 1) begin
            chk("rtrough_pattern", pattern_out, 0);
        end
    endtask

    task automatic learn_one(input int k, input logic [5:0] pat, input bit probe_th,
                             input bit probe_dual, input int next_mode, input bit pause);
        theta_x = 18'sd0;
        sb_check("peak_pattern", pattern_out);
        chk("peak_busy", busy, 1);
        if (probe_th) begin
            theta_x = PEAK_TH - 18'sd1;
            learning = 1'b1;
            repeat (2) tick();
            learning = 1'b0;
            tick();
            chk("below_peak_th", pattern_out, pat);
        end
        theta_x = k[0] ? PEAK_TH : 18'sd20000;
        if (!probe_dual) learning = 1'b1;
        tick();
        theta_x = 18'sd0;
        if (probe_dual) begin
            recalling = 1'b1;
            repeat (2) tick();
            recalling = 1'b0;
            chk("dual_hs_ignored", pattern_out, pat);
            learning = 1'b1;
        end
        repeat (2) tick();
        chk("lhold_pattern", pattern_out, pat);
        chk("lhold_count", learn_count, k - 1);
        learning = 1'b0;
        tick();
        chk("trough_pattern", pattern_out, 0);
        chk("learn_count", learn_count, k);
        theta_x = TROUGH_TH + 18'sd1;
        tick();
        theta_x = TROUGH_TH;
        tick();
        gap_phase(next_mode, pause);
    endtask

    task automatic recall_one(input logic [5:0] cue, input logic [5:0] rec, input bit which,
                              input int next_mode);
        exp_q.push_back(cue);
        tick();
        sb_check("recall_cue", pattern_out);
        theta_x = 18'sd0;
        phase_pattern = 6'h3f;
        recalling = 1'b1;
        repeat (2) tick();
        chk("rhold_cue", pattern_out, cue);
        recalling = 1'b0;
        phase_pattern = rec;
        exp_q.push_back(rec);
        tick();
        phase_pattern = 6'h3f;
        if (which) begin
            sb_check("recall_b", recall_b);
        end else begin
            sb_check("recall_a", recall_a);
            chk("recall_b_untouched", recall_b, 0);
        end
        chk("recall_pattern_off", pattern_out, 0);
        gap_phase(next_mode, 1'b0);
    endtask

    task automatic run_program(input bit pause);
        logic [5:0] pat;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_count", learn_count, 0);
        chk("start_recall_a", recall_a, 0);
        for (int i = 0; i < 10; i++) begin
            pat = (i < 5) ? PA : PB;
            exp_q.push_back(pat);
            learn_one(i + 1, pat, i == 0, i == 1, (i == 9) ? 1 : 0, pause && i == 2);
        end
        recall_one(CA, RA, 1'b0, 1);
        recall_one(CB, RB, 1'b1, 2);
        chk("final_count", learn_count, 10);
        chk("final_recall_a", recall_a, RA);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; theta_x = 18'sd0;
        learning = 1'b0; recalling = 1'b0; phase_pattern = 6'd0;
        pat_a = PA; pat_b = PB; cue_a = CA; cue_b = CB;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pattern", pattern_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", learn_count, 0);
        chk("rst_recall_a", recall_a, 0);
        chk("rst_recall_b", recall_b, 0);
        rst = 1'b0;
        tick();

        clk_en = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        clk_en = 1'b1;
        chk("gated_start_busy", busy, 0);

        run_program(1'b1);
        repeat (5) tick();
        chk("done_held", done, 1);
        chk("done_held_busy", busy, 0);

        // Timeout in LWAIT with learning stuck low.
        start = 1'b1;
        tick();
        start = 1'b0;
        theta_x = PEAK_TH;
        tick();
        theta_x = 18'sd0;
        repeat (TIMEOUT - 1) tick();
        chk("tmo_pre_busy", busy, 1);
        chk("tmo_pre_error", error, 0);
        chk("tmo_pre_pattern", pattern_out, PA);
        tick();
        chk("tmo_error", error, 1);
        chk("tmo_done", done, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_pattern", pattern_out, 0);
        chk("tmo_count", learn_count, 0);

        // Restart, learn once, then reset while in LHOLD.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_error_clr", error, 0);
        chk("restart_done_clr", done, 0);
        exp_q.push_back(PA);
        learn_one(1, PA, 1'b0, 1'b0, 0, 1'b0);
        theta_x = PEAK_TH;
        learning = 1'b1;
        tick();
        theta_x = 18'sd0;
        tick();
        chk("pre_rst_count", learn_count, 1);
        chk("pre_rst_pattern", pattern_out, PA);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pattern", pattern_out, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", learn_count, 0);
        learning = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);
        run_program(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
